lives_manager: RTL and testbench

//  Parametrised player-lives manager for the brick-breaker game. Edge-detects life-lost events,

---
 rtl/lives_pkg.sv | 16 +
 rtl/frame_counter.sv | 36 +++
 rtl/lives_manager.sv | 159 +++++++++++++++
 tb/tb_lives_manager.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lives_pkg.sv
// Shared types and default parameter values for the player-lives manager.
package lives_pkg;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } lives_state_t;

   localparam int DEF_LIVES_W       = 4;
   localparam int DEF_INIT_LIVES    = 3;
   localparam int DEF_MAX_LIVES     = 5;
   localparam int DEF_INVULN_FRAMES = 60;
   localparam int DEF_BLINK_FRAMES  = 8;

endpackage

// File: rtl/frame_counter.sv
// Frame-tick counter: done fires on the tick that brings the count to LIMIT,
// and the count restarts from zero on that same tick.
module frame_counter #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic tick,
   output logic done
);

   localparam int               CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] count_r;

   assign done = tick & (count_r == LAST);

   // Tick counter; clear wins over tick, and reaching LIMIT restarts the count.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (done) begin
         count_r <= {CNT_W{1'b0}};
      end else if (tick) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/lives_manager.sv
// Player-lives manager: edge-detected hits, saturating extra lives,
// frame-timed invulnerability with sprite blinking, and game-over flag.
module lives_manager
   import lives_pkg::*;
#(
   parameter int LIVES_W       = DEF_LIVES_W,
   parameter int INIT_LIVES    = DEF_INIT_LIVES,
   parameter int MAX_LIVES     = DEF_MAX_LIVES,
   parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
   parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               lifeLost,
   input  logic               extraLife,
   input  logic               restart,
   output logic [LIVES_W-1:0] lives,
   output logic               invulnerable,
   output logic               blinkOn,
   output logic               gameOver,
   output logic               hitPulse
);

   localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);
   localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);
   localparam logic [LIVES_W-1:0] ONE_L  = LIVES_W'(1);

   lives_state_t       state_r, state_s;
   logic [LIVES_W-1:0] lives_r, lives_s;
   logic               lost_prev_r, hit_s;
   logic               hit_pulse_r, hit_pulse_s;
   logic               blink_on_r, blink_on_s;
   logic               invuln_r, game_over_r;
   logic               tick_s, clear_s, invuln_done_s, blink_done_s;

   function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] value);
      logic [LIVES_W-1:0] result;
      if (value >= MAX_L) begin
         result = MAX_L;
      end else begin
         result = value + ONE_L;
      end
      return result;
   endfunction

   assign hit_s  = lifeLost & ~lost_prev_r;
   assign tick_s = startOfFrame & (state_r == INVULN);

   frame_counter #(.LIMIT(INVULN_FRAMES)) u_invuln_timer (
      .clk    (clk),
      .resetN (resetN),
      .clear  (clear_s),
      .tick   (tick_s),
      .done   (invuln_done_s)
   );

   frame_counter #(.LIMIT(BLINK_FRAMES)) u_blink_timer (
      .clk    (clk),
      .resetN (resetN),
      .clear  (clear_s),
      .tick   (tick_s),
      .done   (blink_done_s)
   );

   // Next-state, lives arithmetic and blink decision; restart overrides everything.
   always_comb begin
      state_s     = state_r;
      lives_s     = lives_r;
      hit_pulse_s = 1'b0;
      blink_on_s  = blink_on_r;
      clear_s     = 1'b0;
      if (restart) begin
         state_s    = PLAY;
         lives_s    = INIT_L;
         blink_on_s = 1'b1;
         clear_s    = 1'b1;
      end else begin
         case (state_r)
            PLAY: begin
               blink_on_s = 1'b1;
               if (hit_s) begin
                  hit_pulse_s = 1'b1;
                  clear_s     = 1'b1;
                  blink_on_s  = 1'b0;
                  // A same-cycle extra life cancels the deduction, even at one life.
                  if (extraLife) begin
                     state_s = INVULN;
                  end else if (lives_r > ONE_L) begin
                     lives_s = lives_r - ONE_L;
                     state_s = INVULN;
                  end else begin
                     lives_s    = {LIVES_W{1'b0}};
                     state_s    = GAME_OVER;
                     blink_on_s = 1'b1;
                  end
               end else if (extraLife) begin
                  lives_s = sat_inc(lives_r);
               end else begin
                  lives_s = lives_r;
               end
            end
            INVULN: begin
               if (extraLife) begin
                  lives_s = sat_inc(lives_r);
               end else begin
                  lives_s = lives_r;
               end
               if (invuln_done_s) begin
                  state_s    = PLAY;
                  blink_on_s = 1'b1;
               end else if (blink_done_s) begin
                  blink_on_s = ~blink_on_r;
               end else begin
                  blink_on_s = blink_on_r;
               end
            end
            GAME_OVER: begin
               lives_s    = {LIVES_W{1'b0}};
               blink_on_s = 1'b1;
            end
            default: begin
               state_s    = PLAY;
               lives_s    = INIT_L;
               blink_on_s = 1'b1;
               clear_s    = 1'b1;
            end
         endcase
      end
   end

   // Edge register, FSM state and all output registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lost_prev_r <= 1'b0;
         state_r     <= PLAY;
         lives_r     <= INIT_L;
         hit_pulse_r <= 1'b0;
         blink_on_r  <= 1'b1;
         invuln_r    <= 1'b0;
         game_over_r <= 1'b0;
      end else begin
         lost_prev_r <= lifeLost;
         state_r     <= state_s;
         lives_r     <= lives_s;
         hit_pulse_r <= hit_pulse_s;
         blink_on_r  <= blink_on_s;
         invuln_r    <= (state_s == INVULN);
         game_over_r <= (state_s == GAME_OVER);
      end
   end

   assign lives        = lives_r;
   assign invulnerable = invuln_r;
   assign blinkOn      = blink_on_r;
   assign gameOver     = game_over_r;
   assign hitPulse     = hit_pulse_r;

endmodule

// File: tb/tb_lives_manager.sv
// Bench for lives_manager: constant vector table, hand-built frame sequences,
// and random stimulus checked against a frame-count reference model.
module tb_lives_manager;

   localparam int M_INIT  = 3;
   localparam int M_MAX   = 5;
   localparam int M_INV   = 60;
   localparam int M_BLINK = 8;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       lifeLost;
   logic       extraLife;
   logic       restart;
   logic [3:0] lives;
   logic       invulnerable;
   logic       blinkOn;
   logic       gameOver;
   logic       hitPulse;

   lives_manager #(
      .LIVES_W(4), .INIT_LIVES(M_INIT), .MAX_LIVES(M_MAX),
      .INVULN_FRAMES(M_INV), .BLINK_FRAMES(M_BLINK)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .lifeLost     (lifeLost),
      .extraLife    (extraLife),
      .restart      (restart),
      .lives        (lives),
      .invulnerable (invulnerable),
      .blinkOn      (blinkOn),
      .gameOver     (gameOver),
      .hitPulse     (hitPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: lives as an integer, frames elapsed since the hit.
   int m_lives;
   int m_k;
   bit m_inv, m_over, m_hp, m_prev;

   typedef struct packed {
      logic       sof, ll, el, rs;
      logic [3:0] lives;
      logic       inv, blink, over, hp;
   } vec_t;

   vec_t tbl [0:13];

   int hp_count, first_off, toggles, first_blink, last_blink;
   bit ll_rand;

   task automatic model_reset();
      m_lives = M_INIT; m_k = 0; m_inv = 1'b0; m_over = 1'b0; m_hp = 1'b0; m_prev = 1'b0;
   endtask

   function automatic int inc_sat(input int v);
      return (v + 1 > M_MAX) ? M_MAX : v + 1;
   endfunction

   task automatic model_step(input bit sof, input bit ll, input bit el, input bit rs);
      bit hit;
      hit    = ll && !m_prev;
      m_prev = ll;
      m_hp   = 1'b0;
      if (rs) begin
         m_lives = M_INIT; m_inv = 1'b0; m_over = 1'b0; m_k = 0;
      end else if (m_over) begin
         m_lives = 0;
      end else if (m_inv) begin
         if (el) m_lives = inc_sat(m_lives);
         if (sof) begin
            m_k++;
            if (m_k >= M_INV) m_inv = 1'b0;
         end
      end else if (hit) begin
         m_hp = 1'b1;
         if (el) begin
            m_inv = 1'b1; m_k = 0;
         end else if (m_lives > 1) begin
            m_lives--; m_inv = 1'b1; m_k = 0;
         end else begin
            m_lives = 0; m_over = 1'b1;
         end
      end else if (el) begin
         m_lives = inc_sat(m_lives);
      end
   endtask

   function automatic logic [7:0] model_out();
      logic b;
      b = m_inv ? (((m_k / M_BLINK) % 2) == 1) : 1'b1;
      return {4'(m_lives), m_inv, b, m_over, m_hp};
   endfunction

   function automatic logic [7:0] dut_out();
      return {lives, invulnerable, blinkOn, gameOver, hitPulse};
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got lives=%0d inv=%b blink=%b over=%b hit=%b, want lives=%0d inv=%b blink=%b over=%b hit=%b",
                  name, got[7:4], got[3], got[2], got[1], got[0],
                  exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   task automatic step(input bit sof, input bit ll, input bit el, input bit rs, input string name);
      startOfFrame = sof; lifeLost = ll; extraLife = el; restart = rs;
      @(posedge clk);
      model_step(sof, ll, el, rs);
      #1;
      check(name, dut_out(), model_out());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // {sof, ll, el, rs, lives, inv, blink, over, hp}
      tbl[0]  = {4'b0000, 4'd3, 4'b0100};
      tbl[1]  = {4'b0010, 4'd4, 4'b0100};
      tbl[2]  = {4'b0010, 4'd5, 4'b0100};
      tbl[3]  = {4'b0010, 4'd5, 4'b0100};
      tbl[4]  = {4'b0010, 4'd5, 4'b0100};
      tbl[5]  = {4'b0100, 4'd4, 4'b1001};
      tbl[6]  = {4'b0100, 4'd4, 4'b1000};
      tbl[7]  = {4'b0010, 4'd5, 4'b1000};
      tbl[8]  = {4'b0101, 4'd3, 4'b0100};
      tbl[9]  = {4'b0100, 4'd3, 4'b0100};
      tbl[10] = {4'b0000, 4'd3, 4'b0100};
      tbl[11] = {4'b0110, 4'd3, 4'b1001};
      tbl[12] = {4'b1001, 4'd3, 4'b0100};
      tbl[13] = {4'b1000, 4'd3, 4'b0100};

      resetN = 1'b0; startOfFrame = 1'b0; lifeLost = 1'b0; extraLife = 1'b0; restart = 1'b0;
      model_reset();
      #12;
      check("reset_state", dut_out(), {4'd3, 4'b0100});
      @(posedge clk);
      #1 resetN = 1'b1;

      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "idle_frames");
      check("idle_after_10", dut_out(), {4'd3, 4'b0100});

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].sof, tbl[i].ll, tbl[i].el, tbl[i].rs, "tbl_model");
         check($sformatf("tbl%0d", i), dut_out(),
               {tbl[i].lives, tbl[i].inv, tbl[i].blink, tbl[i].over, tbl[i].hp});
      end

      // lifeLost held for 5 frames: single deduction, 60-frame window, 8-frame blink.
      hp_count = 0; toggles = 0; first_off = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, "held_hit");
      hp_count   += int'(hitPulse);
      first_blink = int'(blinkOn);
      last_blink  = int'(blinkOn);
      for (int f = 1; f <= 70; f++) begin
         for (int c = 0; c < 4; c++) begin
            step(c == 3, f <= 5, 1'b0, 1'b0, "held_run");
            hp_count += int'(hitPulse);
            if (invulnerable && int'(blinkOn) != last_blink) toggles++;
            last_blink = int'(blinkOn);
         end
         if (!invulnerable && first_off == 0) first_off = f;
      end
      check_int("held_hit_count", hp_count, 1);
      check_int("held_lives", int'(lives), 2);
      check_int("invuln_frames", first_off, 60);
      check_int("blink_first", first_blink, 0);
      check_int("blink_toggles", toggles, 7);

      // Two more spaced hits run lives down to game over.
      for (int h = 0; h < 2; h++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, "gap_hit");
         check($sformatf("gap_hit%0d", h), dut_out(),
               (h == 0) ? {4'd1, 4'b1001} : {4'd0, 4'b0111});
         for (int f = 0; f < 62; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "gap_run");
      end
      check("game_over_hold", dut_out(), {4'd0, 4'b0110});
      step(1'b0, 1'b1, 1'b1, 1'b0, "go_ignore");
      check("go_ignore_const", dut_out(), {4'd0, 4'b0110});

      step(1'b0, 1'b0, 1'b0, 1'b1, "restart_go");
      check("restart_go_const", dut_out(), {4'd3, 4'b0100});

      // Reach one life, then hit and extra life together.
      step(1'b0, 1'b1, 1'b0, 1'b0, "to_two");
      for (int f = 0; f < 60; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "wait_a");
      step(1'b0, 1'b1, 1'b0, 1'b0, "to_one");
      for (int f = 0; f < 60; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "wait_b");
      step(1'b0, 1'b1, 1'b1, 1'b0, "hit_extra_one");
      check("hit_extra_one_const", dut_out(), {4'd1, 4'b1001});

      // Extra life mid-window leaves the timer running.
      for (int f = 0; f < 10; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "inv_run");
      step(1'b0, 1'b0, 1'b1, 1'b0, "inv_extra");
      check("inv_extra_const", dut_out(), {4'd2, 4'b1100});
      for (int f = 0; f < 49; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "inv_run2");
      check("inv_frame59", dut_out(), {4'd2, 4'b1100});
      step(1'b1, 1'b0, 1'b0, 1'b0, "inv_exit");
      check("inv_exit_const", dut_out(), {4'd2, 4'b0100});

      // Restart mid-window with a concurrent rising lifeLost.
      step(1'b0, 1'b1, 1'b0, 1'b0, "mid_hit");
      for (int f = 0; f < 5; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "mid_run");
      step(1'b0, 1'b0, 1'b0, 1'b0, "mid_idle");
      step(1'b0, 1'b1, 1'b0, 1'b1, "mid_restart");
      check("mid_restart_const", dut_out(), {4'd3, 4'b0100});

      // Asynchronous reset while invulnerable with blink high.
      step(1'b0, 1'b0, 1'b0, 1'b0, "pre_idle");
      step(1'b0, 1'b1, 1'b0, 1'b0, "pre_hit");
      for (int f = 0; f < 10; f++) step(1'b1, 1'b0, 1'b0, 1'b0, "pre_run");
      check("pre_reset", dut_out(), {4'd2, 4'b1100});
      startOfFrame = 1'b0; lifeLost = 1'b0; extraLife = 1'b0; restart = 1'b0;
      #2 resetN = 1'b0;
      #1;
      check("async_reset", dut_out(), {4'd3, 4'b0100});
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 resetN = 1'b1;

      ll_rand = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) ll_rand = ~ll_rand;
         step($urandom_range(0, 3) == 0, ll_rand, $urandom_range(0, 39) == 0,
              $urandom_range(0, 599) == 0, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
